// File: rtl/his_peak_reader.sv
// his_peak_reader: scans PIXELS histograms from RAM and reports the peak bin of each.
// Optional macro PEAK_CLEAR_EN clears every bin the cycle after it is read.
module his_peak_reader #(
   parameter int NB     = 10,
   parameter int CNT_W  = 8,
   parameter int ADDR_W = 14,
   parameter int PIXELS = 16,
   parameter int BINS   = 1024
) (
   input  logic              clk,
   input  logic              res,
   input  logic              start,
   output logic [ADDR_W-1:0] raddr,
   output logic              rEnable,
   input  logic [CNT_W-1:0]  counts,
   output logic [ADDR_W-1:0] waddr,
   output logic              wEnable,
   output logic [CNT_W-1:0]  wdata,
   output logic [7:0]        peak_pixel,
   output logic [NB-1:0]     peak_bin,
   output logic [CNT_W-1:0]  peak_cnt,
   output logic              peak_valid,
   input  logic              peak_ready,
   output logic              busy,
   output logic              done
);

   localparam int PW = (PIXELS > 1) ? $clog2(PIXELS) : 1;

   typedef enum logic [2:0] {IDLE, SCAN, FLUSH, OUT, DONE} state_t;

   state_t            state;
   state_t            state_nxt;
   logic [NB-1:0]     bin;
   logic [ADDR_W-1:0] addr;
   logic [PW-1:0]     pixel;
   logic              last_bin;
   logic              last_pix;
   logic              hs;
   logic              cmp_vld;
   logic              cmp_first;
   logic [NB-1:0]     cmp_bin;
   logic [NB-1:0]     max_bin;
   logic [CNT_W-1:0]  max_cnt;

   assign last_bin = (bin == NB'(BINS - 1));
   assign last_pix = (pixel == PW'(PIXELS - 1));
   assign hs       = (state == OUT) && peak_ready;

   assign peak_pixel = 8'(pixel);
   assign peak_bin   = max_bin;
   assign peak_cnt   = max_cnt;

   // state register
   always_ff @(posedge clk or negedge res) begin
      if (!res) state <= IDLE;
      else      state <= state_nxt;
   end

   // next state and state-decoded outputs
   always_comb begin
      state_nxt  = state;
      rEnable    = 1'b0;
      raddr      = '0;
      peak_valid = 1'b0;
      busy       = 1'b1;
      done       = 1'b0;
      unique case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) state_nxt = SCAN;
         end
         SCAN: begin
            rEnable = 1'b1;
            raddr   = addr;
            if (last_bin) state_nxt = FLUSH;
         end
         FLUSH: state_nxt = OUT;
         OUT: begin
            peak_valid = 1'b1;
            if (peak_ready) state_nxt = last_pix ? DONE : SCAN;
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // bin, address and pixel counters; all wrap to 0 when the scan completes
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         bin   <= '0;
         addr  <= '0;
         pixel <= '0;
      end else begin
         if (state == SCAN) begin
            bin  <= last_bin ? '0 : bin + 1'b1;
            addr <= (last_bin && last_pix) ? '0 : addr + 1'b1;
         end
         if (hs) pixel <= last_pix ? '0 : pixel + 1'b1;
      end
   end

   // read-data alignment: tag each returning word with its bin
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         cmp_vld   <= 1'b0;
         cmp_first <= 1'b0;
         cmp_bin   <= '0;
      end else begin
         cmp_vld   <= (state == SCAN);
         cmp_first <= (bin == '0);
         cmp_bin   <= bin;
      end
   end

   // running maximum; strict compare keeps the lowest bin on ties
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         max_bin <= '0;
         max_cnt <= '0;
      end else if (cmp_vld && (cmp_first || counts > max_cnt)) begin
         max_bin <= cmp_bin;
         max_cnt <= counts;
      end
   end

`ifdef PEAK_CLEAR_EN
   logic [ADDR_W-1:0] clr_addr;

   // write zero to the word read in the previous cycle
   always_ff @(posedge clk or negedge res) begin
      if (!res) clr_addr <= '0;
      else      clr_addr <= rEnable ? raddr : '0;
   end

   assign waddr   = clr_addr;
   assign wEnable = cmp_vld;
   assign wdata   = '0;
`else
   assign waddr   = '0;
   assign wEnable = 1'b0;
   assign wdata   = '0;
`endif

endmodule

// File: doc/his_peak_reader.md
HIS_PEAK_READER -- requirements
Module: his_peak_reader

Interface
REQ-001 SHALL have parameter NB, default 10: bin index width.
REQ-002 SHALL have parameter CNT_W, default 8: bin count width.
REQ-003 SHALL have parameter ADDR_W, default 14: histogram RAM address width.
REQ-004 SHALL have parameter PIXELS, default 16: pixels (histograms) per RAM.
REQ-005 SHALL have parameter BINS, default 1024: bins per histogram; PIXELS*BINS <= 2^ADDR_W.
REQ-006 SHALL use one clock and an asynchronous active-low reset: clk, input, 1, rising-edge clock.
REQ-007 res, input, 1, asynchronous active-low reset.
REQ-008 start, input, 1, histogram build complete; begin scan.
REQ-009 raddr, output, ADDR_W, RAM read-port address.
REQ-010 rEnable, output, 1, RAM read enable, active-high.
REQ-011 counts, input, CNT_W, RAM read data, valid one cycle after rEnable.
REQ-012 waddr / wEnable / wdata, output, ADDR_W / 1 / CNT_W, RAM write port (clear feature only).
REQ-013 peak_pixel / peak_bin / peak_cnt, output, 8 / NB / CNT_W, result of current pixel.
REQ-014 peak_valid, output, 1; peak_ready, input, 1: result handshake.
REQ-015 busy, output, 1, scan in progress; done, output, 1, one-cycle pulse at scan end.

Function
REQ-016 SHALL implement states IDLE, SCAN, FLUSH, OUT, DONE.
REQ-017 IDLE: start=1 -> SCAN; start ignored in every other state.
REQ-018 SCAN: rEnable=1, raddr=pixel*BINS+bin, bin increments every cycle; after bin BINS-1 issued -> FLUSH.
REQ-019 Compare uses counts from previous cycle's read; first bin of each pixel loads max unconditionally.
REQ-020 Update max only if counts > max (strict); ties keep lowest bin index.
REQ-021 FLUSH: rEnable=0, compare last bin, -> OUT.
REQ-022 OUT: peak_valid=1, outputs stable until peak_valid&peak_ready; then next pixel -> SCAN, or after pixel PIXELS-1 -> DONE.
REQ-023 DONE: done=1 for exactly one cycle, -> IDLE; busy=1 in SCAN/FLUSH/OUT/DONE only.
REQ-024 Per-pixel latency from SCAN entry to peak_valid: BINS+1 cycles.
REQ-025 Counts of all-zero histogram -> peak_bin=0, peak_cnt=0.
REQ-026 raddr SHALL never exceed PIXELS*BINS-1; pixel and bin counters wrap to 0 on scan completion.

Reset
REQ-027 res low SHALL force IDLE immediately, mid-scan included, abandoning the scan without a result or done.
REQ-028 Reset values: raddr=0, rEnable=0, waddr=0, wEnable=0, wdata=0, peak_*=0, peak_valid=0, busy=0, done=0.

Configuration
REQ-029 Macro PEAK_CLEAR_EN defined: each bin read in SCAN SHALL be cleared the following cycle via waddr=previous raddr, wEnable=1, wdata=0.
REQ-030 PEAK_CLEAR_EN undefined: wEnable, waddr, wdata SHALL be held at 0; RAM contents untouched.

Verification
REQ-031 BINS=8, PIXELS=2, pixel0 counts {1,5,3,5,0,0,0,2}, peak_ready=1 -> peak_pixel=0, peak_bin=1, peak_cnt=5, valid 9 cycles after SCAN entry.
REQ-032 Pixel1 all zero -> peak_pixel=1, peak_bin=0, peak_cnt=0; done pulses one cycle after second handshake.
REQ-033 peak_ready held low 5 cycles in OUT -> outputs and peak_valid stable, raddr/rEnable idle, resumes on ready.
REQ-034 start pulsed during SCAN -> ignored, exactly PIXELS results produced.
REQ-035 res asserted mid-SCAN at bin 4 -> all outputs reset same cycle, IDLE, new start rescans from address 0.
REQ-036 PEAK_CLEAR_EN defined -> after scan every RAM word reads 0; undefined -> RAM unchanged, wEnable never 1.
